// File: rtl/param_register_file.sv
// Parametrised register file with a reset-driven init sequencer, Ready handshake,
// registered write-first reads and a sticky fault flag for protected-slot writes.
module param_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int INIT_BASE  = 100,
   parameter int SP_INDEX   = 29,
   parameter int SP_INIT    = 1020,
   parameter int PROT_LO    = 26,
   parameter int PROT_HI    = 27
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic        [ADDR_WIDTH-1:0] ReadReg1,
   input  logic        [ADDR_WIDTH-1:0] ReadReg2,
   input  logic        [ADDR_WIDTH-1:0] WAddr,
   input  logic signed [DATA_WIDTH-1:0] WData,
   input  logic                         RegWrite,
   output logic signed [DATA_WIDTH-1:0] ReadData1,
   output logic signed [DATA_WIDTH-1:0] ReadData2,
   output logic                         Ready,
   output logic                         WriteFault
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [ADDR_WIDTH-1:0]   r_init_idx;
   logic                    r_fault;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
   logic [DATA_WIDTH-1:0]   r_rd1;
   logic [DATA_WIDTH-1:0]   r_rd2;
   logic [DATA_WIDTH-1:0]   w_init_tab [DEPTH];

   logic w_run;
   logic w_wr_prot;
   logic w_wr_nonzero;
   logic w_wr_accept;
   logic w_wr_fault;
   logic w_byp1;
   logic w_byp2;

   // Init table is resolved at elaboration; an empty window (LO > HI) never matches.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
         if (gi == 0) begin : g_zero
            assign w_init_tab[gi] = '0;
         end else if (gi == SP_INDEX) begin : g_sp
            assign w_init_tab[gi] = DATA_WIDTH'(SP_INIT);
         end else if (gi >= PROT_LO && gi <= PROT_HI) begin : g_prot
            assign w_init_tab[gi] = '0;
         end else begin : g_base
            assign w_init_tab[gi] = DATA_WIDTH'(INIT_BASE + gi);
         end
      end
   endgenerate

   assign w_run        = (r_state == ST_RUN);
   assign w_wr_prot    = (int'(WAddr) >= PROT_LO) && (int'(WAddr) <= PROT_HI);
   assign w_wr_nonzero = (WAddr != '0);
   assign w_wr_accept  = w_run && RegWrite && w_wr_nonzero && !w_wr_prot;
   assign w_wr_fault   = w_run && RegWrite && w_wr_nonzero && w_wr_prot;
   assign w_byp1       = w_wr_accept && (WAddr == ReadReg1);
   assign w_byp2       = w_wr_accept && (WAddr == ReadReg2);

   always_comb begin
      w_state_next = r_state;
      if (r_state == ST_INIT && r_init_idx == '1) begin
         w_state_next = ST_RUN;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state    <= ST_INIT;
         r_init_idx <= '0;
         r_fault    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_INIT) begin
            r_init_idx <= r_init_idx + ADDR_WIDTH'(1);
         end
         if (w_wr_fault) begin
            r_fault <= 1'b1;
         end
      end
   end

   // Array has no reset: the init sequence rewrites every entry after Rst.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         if (r_state == ST_INIT) begin
            r_mem[r_init_idx] <= w_init_tab[r_init_idx];
         end else if (w_wr_accept) begin
            r_mem[WAddr] <= WData;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_rd1 <= '0;
         r_rd2 <= '0;
      end else if (r_state == ST_INIT) begin
         r_rd1 <= '0;
         r_rd2 <= '0;
      end else begin
         r_rd1 <= w_byp1 ? WData : ((ReadReg1 == '0) ? '0 : r_mem[ReadReg1]);
         r_rd2 <= w_byp2 ? WData : ((ReadReg2 == '0) ? '0 : r_mem[ReadReg2]);
      end
   end

   assign ReadData1  = r_rd1;
   assign ReadData2  = r_rd2;
   assign Ready      = w_run;
   assign WriteFault = r_fault;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: directed init/bypass/protection steps plus random
// traffic compared against an array-based reference of the register file rules.
module tb_param_register_file;

   localparam int DW       = 32;
   localparam int AW       = 5;
   localparam int DEPTH    = 32;
   localparam int BASE     = 100;
   localparam int SP_IDX   = 29;
   localparam int SP_VAL   = 1020;
   localparam int PLO      = 26;
   localparam int PHI      = 27;

   logic                 Clk = 1'b0;
   logic                 Rst = 1'b1;
   logic        [AW-1:0] ReadReg1 = '0;
   logic        [AW-1:0] ReadReg2 = '0;
   logic        [AW-1:0] WAddr = '0;
   logic signed [DW-1:0] WData = '0;
   logic                 RegWrite = 1'b0;
   logic signed [DW-1:0] ReadData1;
   logic signed [DW-1:0] ReadData2;
   logic                 Ready;
   logic                 WriteFault;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [DEPTH];
   logic        fault_model = 1'b0;

   param_register_file #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_BASE(BASE), .SP_INDEX(SP_IDX),
      .SP_INIT(SP_VAL), .PROT_LO(PLO), .PROT_HI(PHI)
   ) dut (
      .Clk(Clk), .Rst(Rst), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .WAddr(WAddr), .WData(WData), .RegWrite(RegWrite),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .Ready(Ready), .WriteFault(WriteFault)
   );

   always #5 Clk = ~Clk;

   function automatic logic is_prot(input int a);
      return (a >= PLO) && (a <= PHI);
   endfunction

   function automatic logic [31:0] init_val(input int i);
      if (i == 0) return 32'd0;
      if (i == SP_IDX) return 32'(SP_VAL);
      if (is_prot(i)) return 32'd0;
      return 32'(BASE + i);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = init_val(i);
      fault_model = 1'b0;
   endtask

   // Release reset and walk the whole init sequence, driving a write that must be ignored.
   task automatic run_init();
      Rst = 1'b0;
      RegWrite = 1'b1;
      WAddr = 5'd3;
      WData = 32'sd1;
      for (int k = 1; k <= DEPTH; k++) begin
         ReadReg1 = AW'($urandom_range(0, DEPTH - 1));
         ReadReg2 = 5'd3;
         tick();
         chk($sformatf("init_ready_e%0d", k), 32'(Ready), (k == DEPTH) ? 32'd1 : 32'd0);
         if (k < DEPTH) begin
            chk($sformatf("init_rd1_e%0d", k), ReadData1, 32'd0);
         end
      end
      chk("init_fault", 32'(WriteFault), 32'd0);
      RegWrite = 1'b0;
      WAddr = '0;
      WData = '0;
      model_reset();
   endtask

   task automatic xact(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      logic [31:0] e1;
      logic [31:0] e2;
      logic        acc;
      RegWrite = we;
      WAddr    = wa;
      WData    = wd;
      ReadReg1 = r1;
      ReadReg2 = r2;
      acc = we && (wa != 0) && !is_prot(int'(wa));
      e1  = (acc && wa == r1) ? wd : model[r1];
      e2  = (acc && wa == r2) ? wd : model[r2];
      if (acc) model[wa] = wd;
      if (we && wa != 0 && is_prot(int'(wa))) fault_model = 1'b1;
      tick();
      $display("xact we=%0b wa=%0d wd=%h r1=%0d r2=%0d -> rd1=%h rd2=%h fault=%0b",
               we, wa, wd, r1, r2, ReadData1, ReadData2, WriteFault);
      chk($sformatf("rd1[%0d]", r1), ReadData1, e1);
      chk($sformatf("rd2[%0d]", r2), ReadData2, e2);
      chk("fault", 32'(WriteFault), 32'(fault_model));
      chk("ready", 32'(Ready), 32'd1);
   endtask

   initial begin
      logic [AW-1:0] wa;
      logic [AW-1:0] r1;

      Rst = 1'b1;
      repeat (3) tick();
      chk("rst_ready", 32'(Ready), 32'd0);
      chk("rst_rd1", ReadData1, 32'd0);
      chk("rst_rd2", ReadData2, 32'd0);
      chk("rst_fault", 32'(WriteFault), 32'd0);

      run_init();

      // Full read sweep of the initialised file (includes entry 3 after the ignored write).
      for (int i = 0; i < DEPTH; i++) begin
         xact(1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i));
      end

      xact(1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0);
      xact(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
      xact(1'b1, 5'd5, 32'hFFFFFFF9, 5'd5, 5'd5);
      xact(1'b1, 5'd26, 32'd55, 5'd26, 5'd26);
      xact(1'b0, 5'd0, 32'd0, 5'd26, 5'd27);
      xact(1'b1, 5'd0, 32'd9, 5'd0, 5'd0);
      xact(1'b0, 5'd0, 32'd0, 5'd0, 5'd5);

      for (int n = 0; n < 300; n++) begin
         wa = AW'($urandom_range(0, DEPTH - 1));
         r1 = AW'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 3) == 0) r1 = wa;
         xact(1'($urandom_range(0, 1)), wa, $urandom, r1, AW'($urandom_range(0, DEPTH - 1)));
      end

      // Reset again, abort the sequence at index 10, and confirm a full restart.
      Rst = 1'b1;
      tick();
      chk("rst2_fault", 32'(WriteFault), 32'd0);
      chk("rst2_ready", 32'(Ready), 32'd0);
      Rst = 1'b0;
      repeat (10) tick();
      chk("mid_ready", 32'(Ready), 32'd0);
      Rst = 1'b1;
      tick();
      chk("mid_rst_fault", 32'(WriteFault), 32'd0);
      run_init();

      xact(1'b0, '0, '0, 5'd8, 5'd5);
      xact(1'b0, '0, '0, 5'd3, 5'd29);
      xact(1'b0, '0, '0, 5'd26, 5'd31);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the single-cycle register file in the datapath.
- Width, depth, stack-pointer slot and the protected (kernel) slot window are configurable.
- Adds a reset-driven initialisation sequencer, a Ready handshake, registered reads with write-through bypass, and a sticky fault flag for writes to protected slots.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
INIT_BASE, 100, init value offset: entry i initialises to INIT_BASE + i
SP_INDEX, 29, index of stack-pointer entry
SP_INIT, 1020, init value of SP_INDEX entry
PROT_LO, 26, lowest protected (write-blocked, init 0) index
PROT_HI, 27, highest protected index; PROT_LO > PROT_HI disables protection

Ports:
Clk  input  1  clock, all state on rising edge
Rst  input  1  synchronous, active-high reset; starts init sequence
ReadReg1  input  ADDR_WIDTH  read port 1 address
ReadReg2  input  ADDR_WIDTH  read port 2 address
WAddr  input  ADDR_WIDTH  write address
WData  input  DATA_WIDTH  write data, signed
RegWrite  input  1  write enable
ReadData1  output  DATA_WIDTH  registered read data port 1, signed
ReadData2  output  DATA_WIDTH  registered read data port 2, signed
Ready  output  1  high when file accepts reads/writes
WriteFault  output  1  sticky: a write to a protected index was attempted

Behaviour:
- States: INIT, RUN. Counter InitIdx (ADDR_WIDTH bits).
- Rst high at a rising edge, in any state or mid-sequence: next state INIT, InitIdx=0, Ready=0, ReadData1/2=0, WriteFault=0. Array contents are not cleared by Rst itself; the sequence overwrites them.
- INIT: each cycle writes entry InitIdx with its init value, then increments InitIdx.
  - Init values: index 0 gets 0; SP_INDEX gets SP_INIT; PROT_LO..PROT_HI get 0; every other entry gets INIT_BASE + i, truncated to DATA_WIDTH.
  - Init values are fixed for indices 1, 28, 30 and 31 as well; no index is left uninitialised.
  - After InitIdx = DEPTH-1 is written, the next state is RUN. InitIdx wraps to 0 and is unused.
  - Rst deasserted at edge E: entry 0 is written at E+1, the last entry at E+DEPTH, and Ready=1 after that edge. The sequence therefore takes DEPTH cycles.
  - During INIT, RegWrite is ignored (no array write, no fault) and ReadData1/2 are held at 0.
- RUN: Ready=1.
  - Write: on a rising edge with RegWrite=1, the array is written when WAddr != 0 and WAddr is outside [PROT_LO, PROT_HI].
  - RegWrite=1 with WAddr in the protected window: no write, and WriteFault is set to 1 on that edge. It stays 1 until Rst.
  - RegWrite=1 with WAddr=0: silently dropped, no fault.
  - Read: ReadDataN at edge T+1 equals the entry at ReadRegN sampled at edge T, giving 1-cycle latency.
  - Bypass: if at the same edge RegWrite=1, the write is accepted (non-zero, unprotected) and WAddr==ReadRegN, then ReadDataN takes WData (write-first).
  - Rejected writes never bypass. Reading index 0 always returns 0.
  - Both read ports may address the same entry; both return the same value.
- Widths: all data is signed DATA_WIDTH with no extension logic. Addresses cover DEPTH exactly, so there is no out-of-range case.

Test Plan:
- Reset with Rst=1 for 3 cycles, then release -> Ready=0 for 32 cycles and 1 on the 32nd edge after release. Reading entries 0, 2, 25, 26, 29, 31 then returns 0, 102, 125, 0, 1020, 131.
- RUN: write 8 <= 32'hDEADBEEF, then read ReadReg1=8 next cycle -> ReadData1=32'hDEADBEEF one cycle after the address is applied.
- Same-cycle bypass: RegWrite=1, WAddr=5, WData=-7, ReadReg1=ReadReg2=5 -> both ports return -7 after that edge. No stale value 105 appears.
- Protected and zero writes:
  - Write 26 <= 55 -> WriteFault=1 next cycle, and entry 26 still reads 0. Bypass with ReadReg1=26 in the same cycle returns 0.
  - Write 0 <= 9 -> reads 0, and WriteFault is unchanged.
- Reset mid-init: assert Rst at InitIdx=10 -> InitIdx restarts at 0, Ready stays 0 for a further full 32 cycles, and WriteFault clears.
- Writes during INIT: RegWrite=1, WAddr=3, WData=1 while Ready=0 -> after Ready rises, entry 3 reads 103.
